// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  // States in which the loader is consuming stream bytes.
  function automatic logic is_loading(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [7:0]       i_byte,
  output logic [INS_W-1:0] o_word,
  output logic             o_word_valid
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [INS_W-1:0] r_word;
  logic [IDX_W-1:0] r_idx;
  logic             w_last;

  assign w_last = (r_idx == IDX_W'(WORD_BYTES - 1));

  // Partial word storage and byte index; index returns to 0 after the top byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= {INS_W{1'b0}};
      r_idx  <= {IDX_W{1'b0}};
    end else if (i_clear) begin
      r_word <= {INS_W{1'b0}};
      r_idx  <= {IDX_W{1'b0}};
    end else if (i_valid) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx <= w_last ? {IDX_W{1'b0}} : r_idx + 1'b1;
    end else begin
      r_word <= r_word;
      r_idx  <= r_idx;
    end
  end

  // The top byte bypasses storage so the full word is available on the same cycle.
  always_comb begin
    o_word               = r_word;
    o_word[INS_W-1 -: 8] = i_byte;
    o_word_valid         = i_valid && w_last;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length header, LE payload words, XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   we,
  output logic [INS_ADDRESS-1:0] wa,
  output logic [INS_W-1:0]       wd,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   core_hold
);

  localparam int LEN_W = 8 * LEN_BYTES;
  localparam int CNT_W = INS_ADDRESS - 1;
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** (INS_ADDRESS - 2));

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_wcnt;
  logic [7:0]       r_chk;

  logic             w_accept, w_start_go, w_pack_valid, w_word_valid, w_last_word;
  logic [LEN_W-1:0] w_len_full;
  logic [CNT_W-1:0] w_wcnt_inc;
  logic [INS_W-1:0] w_word;

  assign w_accept     = in_valid && in_ready;
  assign w_start_go   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_pack_valid = w_accept && (r_state == ST_DATA);
  assign w_len_full   = {in_data, r_len_lo};
  assign w_wcnt_inc   = r_wcnt + 1'b1;
  assign w_last_word  = w_word_valid && ({{(LEN_W-CNT_W){1'b0}}, w_wcnt_inc} == r_len);

  byte_packer #(.INS_W(INS_W)) u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start_go),
    .i_valid      (w_pack_valid),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_start_go) w_state_nxt = ST_LEN_LO;
        else            w_state_nxt = r_state;
      end
      ST_LEN_LO: begin
        if (w_accept) w_state_nxt = ST_LEN_HI;
        else          w_state_nxt = r_state;
      end
      ST_LEN_HI: begin
        if (!w_accept)                  w_state_nxt = r_state;
        else if (w_len_full > DEPTH)    w_state_nxt = ST_ERR;
        else if (w_len_full == '0)      w_state_nxt = ST_CHECK;
        else                            w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_last_word) w_state_nxt = ST_CHECK;
        else             w_state_nxt = r_state;
      end
      ST_CHECK: begin
        if (!w_accept)              w_state_nxt = r_state;
        else if (in_data == r_chk)  w_state_nxt = ST_DONE;
        else                        w_state_nxt = ST_ERR;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      in_ready  <= is_loading(w_state_nxt);
      busy      <= is_loading(w_state_nxt);
      done      <= (w_state_nxt == ST_DONE);
      error     <= (w_state_nxt == ST_ERR);
      core_hold <= (w_state_nxt != ST_DONE);
    end
  end

  // Length capture, word counter, checksum and memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_lo <= 8'h00;
      r_len    <= {LEN_W{1'b0}};
      r_wcnt   <= {CNT_W{1'b0}};
      r_chk    <= 8'h00;
      we       <= 1'b0;
      wa       <= {INS_ADDRESS{1'b0}};
      wd       <= {INS_W{1'b0}};
    end else begin
      we <= 1'b0;
      if (w_start_go) begin
        r_len_lo <= 8'h00;
        r_len    <= {LEN_W{1'b0}};
        r_wcnt   <= {CNT_W{1'b0}};
        r_chk    <= 8'h00;
      end else if (w_accept && (r_state == ST_LEN_LO)) begin
        r_len_lo <= in_data;
      end else if (w_accept && (r_state == ST_LEN_HI)) begin
        r_len <= w_len_full;
      end else if (w_pack_valid) begin
        r_chk <= r_chk ^ in_data;
        if (w_word_valid) begin
          we     <= 1'b1;
          wa     <= {r_wcnt[INS_ADDRESS-3:0], 2'b00};
          wd     <= w_word;
          r_wcnt <= w_wcnt_inc;
        end else begin
          r_wcnt <= r_wcnt;
        end
      end else begin
        r_chk <= r_chk;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [8:0]  wa;
  logic [31:0] wd;
  logic        busy, done, error, core_hold;

  imem_loader #(.INS_ADDRESS(9), .INS_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
    .error(error), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim[$];
  logic [8:0]  exp_a[$];
  logic [31:0] exp_d[$];
  logic [8:0]  obs_a[$];
  logic [31:0] obs_d[$];
  logic        exp_done, exp_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Capture every memory write pulse.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      obs_a.push_back(wa);
      obs_d.push_back(wd);
    end
  end

  // Reference: parse the byte stream by the format rules.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_a.delete();
    exp_d.delete();
    n = int'({stim[1], stim[0]});
    if (n > 128) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_a.push_back(9'(4 * i));
        exp_d.push_back({stim[5+4*i], stim[4+4*i], stim[3+4*i], stim[2+4*i]});
        for (int b = 0; b < 4; b++) x = x ^ stim[2+4*i+b];
      end
      exp_done = (stim[2+4*n] == x);
      exp_err  = !exp_done;
    end
  endtask

  task automatic build_image(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    if (n <= 128) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stim.push_back(b);
        x = x ^ b;
      end
      stim.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    end
  endtask

  // Pulse start, then stream `limit` bytes with random gaps; ends one negedge after the last accept.
  task automatic run_stream(input int limit, input int gap_pct, input bit poke);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    obs_a.delete();
    obs_d.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < limit && cyc < 4000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? stim[idx] : 8'($urandom);
      start    = poke && (cyc == 6);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_val("stream_drained", 64'(idx), 64'(limit));
  endtask

  task automatic run_and_check(input string tag, input int gap_pct, input bit poke);
    model();
    run_stream(stim.size(), gap_pct, poke);
    check_val({tag, "_done"}, 64'(done), 64'(exp_done));
    check_val({tag, "_error"}, 64'(error), 64'(exp_err));
    check_val({tag, "_hold"}, 64'(core_hold), 64'(!exp_done));
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_ready"}, 64'(in_ready), 64'd0);
    check_val({tag, "_nwrites"}, 64'(obs_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      check_val({tag, "_wa"}, 64'(obs_a[i]), 64'(exp_a[i]));
      check_val({tag, "_wd"}, 64'(obs_d[i]), 64'(exp_d[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 64'(in_ready), 64'd0);
    check_val({tag, "_we"}, 64'(we), 64'd0);
    check_val({tag, "_wa"}, 64'(wa), 64'd0);
    check_val({tag, "_wd"}, 64'(wd), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_error"}, 64'(error), 64'd0);
    check_val({tag, "_hold"}, 64'(core_hold), 64'd1);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    stim = '{8'h02, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00, 8'h33, 8'h70, 8'h00, 8'h00, 8'h40};
    run_and_check("n2", 0, 1'b0);
    if (obs_d.size() >= 2) begin
      check_val("n2_word0", 64'(obs_d[0]), 64'h00108093);
      check_val("n2_addr1", 64'(obs_a[1]), 64'd4);
      check_val("n2_word1", 64'(obs_d[1]), 64'h00007033);
    end

    stim[10] = 8'h00;
    run_and_check("n2_badchk", 0, 1'b0);

    stim = '{8'h81, 8'h00};
    run_and_check("n129", 0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("n129_ready_low", 64'(in_ready), 64'd0);

    stim = '{8'h00, 8'h00, 8'h00};
    run_and_check("n0", 0, 1'b0);

    build_image(5, 1'b1);
    run_and_check("n5_gapless", 0, 1'b0);
    run_and_check("n5_gaps_start", 40, 1'b1);

    build_image(3, 1'b1);
    model();
    run_stream(8, 20, 1'b0);
    check_val("midrst_writes", 64'(obs_a.size()), 64'd1);
    if (obs_d.size() >= 1) check_val("midrst_word0", 64'(obs_d[0]), 64'(exp_d[0]));
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_and_check("after_rst", 0, 1'b0);

    build_image(128, 1'b1);
    run_and_check("full_depth", 10, 1'b0);

    for (int t = 0; t < 6; t++) begin
      build_image($urandom_range(1, 12), ($urandom_range(3) != 0));
      run_and_check("rand", $urandom_range(50), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
